pwm_multich_core: RTL and testbench

//  Parametrised successor of the fixed 8-channel PWM core: NUM_CH channels of complementary
//  PWM (A/B pairs) sharing one prescaler and one up-counter, programmed over the simple

---
 rtl/pwm_multich_core.sv | 224 ++++++++++++++++++++++
 tb/tb_pwm_multich_core.sv | 339 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pwm_multich_core.sv
// ---------------------------------------------------------------------------
// pwm_multich_core
//   NUM_CH channels of complementary PWM sharing one prescaler and one
//   up-counter. Registers are programmed over a simple addr/wr/rd bus.
//   Period and compare values are double-buffered: bus writes land in shadow
//   registers and are copied to the active set on counter wrap, on FORCE_LOAD,
//   or continuously while the core is disabled.
//
//   Optional feature macro: PWM_DEADTIME_EN
//     defined   : per-channel dead-time FSM inserts DT both-low clocks around
//                 every reference edge; DT register (0x03) is read/write.
//     undefined : pwm_a_o = ref, pwm_b_o = EN & ~ref; DT writes ignored,
//                 DT reads return 0.
//
// Ports
//   clk       PWM clock, rising edge
//   rst       synchronous reset, active-high
//   addr_i    register address
//   wr_en_i   1-cycle write strobe
//   rd_en_i   1-cycle read strobe
//   wdata_i   write data
//   rdata_o   read data, valid one cycle after rd_en_i
//   pwm_a_o   primary outputs, bit n = channel n
//   pwm_b_o   complementary outputs
//   period_o  1-cycle pulse on counter wrap
//
// Register map: 0x00 CTRL[0]=EN [1]=FORCE_LOAD (reads 0), 0x01 PSC,
//   0x02 ARR, 0x03 DT, 0x10+n CCR[n].
// ---------------------------------------------------------------------------
module pwm_multich_core #(
  parameter int WIDTH  = 16,
  parameter int NUM_CH = 8,
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic              wr_en_i,
  input  logic              rd_en_i,
  input  logic [WIDTH-1:0]  wdata_i,
  output logic [WIDTH-1:0]  rdata_o,
  output logic [NUM_CH-1:0] pwm_a_o,
  output logic [NUM_CH-1:0] pwm_b_o,
  output logic              period_o
);

  localparam logic [ADDR_W-1:0] ADDR_CTRL = ADDR_W'(0);
  localparam logic [ADDR_W-1:0] ADDR_PSC  = ADDR_W'(1);
  localparam logic [ADDR_W-1:0] ADDR_ARR  = ADDR_W'(2);
`ifdef PWM_DEADTIME_EN
  localparam logic [ADDR_W-1:0] ADDR_DT   = ADDR_W'(3);

  typedef enum logic [1:0] {A_ON, DEAD, B_ON} dt_state_e;

  logic [WIDTH-1:0] dt_q;
`endif

  logic                         en_q;
  logic [WIDTH-1:0]             psc_sh_q, arr_sh_q;
  logic [WIDTH-1:0]             psc_act_q, arr_act_q;
  logic [WIDTH-1:0]             psc_cnt_q, psc_cnt_d;
  logic [WIDTH-1:0]             cnt_q, cnt_d;
  logic                         period_q;
  logic [WIDTH-1:0]             rdata_q, rdata_d;
  logic [NUM_CH-1:0][WIDTH-1:0] ccr_sh_w;

  logic       wr_ctrl, force_load, en_d, run, tick, wrap, load_act;
  logic       ccr_hit;
  logic [3:0] ccr_idx;

  // CCR window is 0x10..0x10+NUM_CH-1
  assign ccr_idx = addr_i[3:0];
  assign ccr_hit = (addr_i[ADDR_W-1:4] == (ADDR_W-4)'(1)) && ({1'b0, ccr_idx} < 5'(NUM_CH));

  assign wr_ctrl    = wr_en_i && (addr_i == ADDR_CTRL);
  assign force_load = wr_ctrl && wdata_i[1];
  assign en_d       = wr_ctrl ? wdata_i[0] : en_q;
  // Disabling takes effect on the write edge itself so outputs drop next
  // cycle; enabling starts one cycle later, once *_act holds fresh values.
  assign run        = en_q && en_d;
  assign tick       = (psc_cnt_q == psc_act_q);
  assign wrap       = run && tick && (cnt_q == arr_act_q);
  // Active set tracks the shadows while disabled, so enabling starts clean.
  assign load_act   = !en_q || wrap || force_load;

  always_comb begin
    psc_cnt_d = psc_cnt_q + WIDTH'(1);
    cnt_d     = cnt_q;
    if (!run || force_load) begin
      psc_cnt_d = '0;
      cnt_d     = '0;
    end else if (tick) begin
      psc_cnt_d = '0;
      cnt_d     = (cnt_q == arr_act_q) ? '0 : cnt_q + WIDTH'(1);
    end
  end

  always_comb begin
    rdata_d = '0;
    if (ccr_hit) begin
      for (int n = 0; n < NUM_CH; n++) begin
        if (ccr_idx == 4'(n)) rdata_d = ccr_sh_w[n];
      end
    end else begin
      case (addr_i)
        ADDR_CTRL: rdata_d = WIDTH'(en_q);
        ADDR_PSC:  rdata_d = psc_sh_q;
        ADDR_ARR:  rdata_d = arr_sh_q;
`ifdef PWM_DEADTIME_EN
        ADDR_DT:   rdata_d = dt_q;
`endif
        default:   rdata_d = '0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      en_q      <= 1'b0;
      psc_sh_q  <= '0;
      arr_sh_q  <= '0;
      psc_act_q <= '0;
      arr_act_q <= '0;
      psc_cnt_q <= '0;
      cnt_q     <= '0;
      period_q  <= 1'b0;
      rdata_q   <= '0;
`ifdef PWM_DEADTIME_EN
      dt_q      <= '0;
`endif
    end else begin
      en_q      <= en_d;
      psc_cnt_q <= psc_cnt_d;
      cnt_q     <= cnt_d;
      period_q  <= wrap;
      // Non-blocking: a write coinciding with wrap loads the pre-write shadow.
      if (load_act) begin
        psc_act_q <= psc_sh_q;
        arr_act_q <= arr_sh_q;
      end
      if (wr_en_i && (addr_i == ADDR_PSC)) psc_sh_q <= wdata_i;
      if (wr_en_i && (addr_i == ADDR_ARR)) arr_sh_q <= wdata_i;
`ifdef PWM_DEADTIME_EN
      if (wr_en_i && (addr_i == ADDR_DT))  dt_q     <= wdata_i;
`endif
      if (rd_en_i) rdata_q <= rdata_d;
    end
  end

  generate
    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
      logic [WIDTH-1:0] ccr_sh_q, ccr_act_q;
      logic             cmp;
      logic             a_q, b_q;

      assign cmp          = run && (cnt_q < ccr_act_q);
      assign ccr_sh_w[gi] = ccr_sh_q;
      assign pwm_a_o[gi]  = a_q;
      assign pwm_b_o[gi]  = b_q;

      always_ff @(posedge clk) begin
        if (rst) begin
          ccr_sh_q  <= '0;
          ccr_act_q <= '0;
        end else begin
          if (load_act) ccr_act_q <= ccr_sh_q;
          if (wr_en_i && ccr_hit && (ccr_idx == 4'(gi))) ccr_sh_q <= wdata_i;
        end
      end

`ifdef PWM_DEADTIME_EN
      dt_state_e        st_q;
      logic [WIDTH-1:0] dtc_q;
      logic             ref_q;

      always_ff @(posedge clk) begin
        if (rst) begin
          st_q  <= B_ON;
          dtc_q <= '0;
          ref_q <= 1'b0;
          a_q   <= 1'b0;
          b_q   <= 1'b0;
        end else begin
          ref_q <= cmp;
          if (!run) begin
            st_q  <= B_ON;
            dtc_q <= '0;
            a_q   <= 1'b0;
            b_q   <= 1'b0;
          end else if ((cmp != ref_q) && (dt_q != '0)) begin
            // Any reference edge (re)starts the dead band.
            st_q  <= DEAD;
            dtc_q <= WIDTH'(1);
            a_q   <= 1'b0;
            b_q   <= 1'b0;
          end else if ((st_q == DEAD) && (dtc_q < dt_q)) begin
            dtc_q <= dtc_q + WIDTH'(1);
            a_q   <= 1'b0;
            b_q   <= 1'b0;
          end else begin
            st_q  <= cmp ? A_ON : B_ON;
            a_q   <= cmp;
            b_q   <= !cmp;
          end
        end
      end
`else
      always_ff @(posedge clk) begin
        if (rst) begin
          a_q <= 1'b0;
          b_q <= 1'b0;
        end else begin
          a_q <= cmp;
          b_q <= run && !cmp;
        end
      end
`endif
    end
  endgenerate

  assign rdata_o  = rdata_q;
  assign period_o = period_q;

endmodule

// File: tb/tb_pwm_multich_core.sv
`timescale 1ns/1ps
module tb_pwm_multich_core;
  localparam int W   = 16;
  localparam int NCH = 8;
  localparam int AW  = 8;
`ifdef PWM_DEADTIME_EN
  localparam int UNM_LO = 4;
`else
  localparam int UNM_LO = 3;
`endif

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic [AW-1:0]  addr = '0;
  logic           wr_en = 1'b0;
  logic           rd_en = 1'b0;
  logic [W-1:0]   wdata = '0;
  logic [W-1:0]   rdata;
  logic [NCH-1:0] pwm_a, pwm_b;
  logic           period;

  pwm_multich_core #(.WIDTH(W), .NUM_CH(NCH), .ADDR_W(AW)) dut (
    .clk(clk), .rst(rst), .addr_i(addr), .wr_en_i(wr_en), .rd_en_i(rd_en),
    .wdata_i(wdata), .rdata_o(rdata), .pwm_a_o(pwm_a), .pwm_b_o(pwm_b),
    .period_o(period)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;
  bit chk_en   = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
  endtask

  // ---------------- reference model (register file + timebase) -------------
  logic [W-1:0]   m_psc = '0, m_arr = '0, m_dt = '0;
  logic [W-1:0]   m_ccr [NCH];
  logic [W-1:0]   a_psc = '0, a_arr = '0;
  logic [W-1:0]   a_ccr [NCH];
  bit             m_en = 1'b0;
  int             m_cnt = 0, m_pc = 0;
  logic [NCH-1:0] m_a = '0, m_b = '0;
  logic           m_period = 1'b0;
  logic [W-1:0]   m_rd = '0;
  bit             m_rprev [NCH];
  int             m_dc [NCH];

  function automatic logic [W-1:0] m_read(input logic [AW-1:0] a);
    if (a == 8'h00) return W'(m_en);
    if (a == 8'h01) return m_psc;
    if (a == 8'h02) return m_arr;
`ifdef PWM_DEADTIME_EN
    if (a == 8'h03) return m_dt;
`endif
    if (a >= 8'h10 && int'(a) < 16 + NCH) return m_ccr[int'(a) - 16];
    return '0;
  endfunction

  always @(posedge clk) begin : model
    bit run, wrap, fl, r;
    if (rst) begin
      m_psc = '0; m_arr = '0; m_dt = '0; a_psc = '0; a_arr = '0;
      m_en = 1'b0; m_cnt = 0; m_pc = 0; m_a = '0; m_b = '0;
      m_period = 1'b0; m_rd = '0;
      for (int n = 0; n < NCH; n++) begin
        m_ccr[n] = '0; a_ccr[n] = '0; m_rprev[n] = 1'b0; m_dc[n] = 0;
      end
    end else begin
      // run: enabled now and not being disabled by this very write
      run  = m_en && !(wr_en && addr == 8'h00 && !wdata[0]);
      wrap = run && (m_pc == int'(a_psc)) && (m_cnt == int'(a_arr));
      for (int n = 0; n < NCH; n++) begin
        r = run && (m_cnt < int'(a_ccr[n]));
`ifdef PWM_DEADTIME_EN
        if (!run) begin
          m_a[n] = 1'b0; m_b[n] = 1'b0; m_dc[n] = 0;
        end else if (r != m_rprev[n] && m_dt != 0) begin
          m_dc[n] = int'(m_dt) - 1; m_a[n] = 1'b0; m_b[n] = 1'b0;
        end else if (m_dc[n] > 0) begin
          m_dc[n]--; m_a[n] = 1'b0; m_b[n] = 1'b0;
        end else begin
          m_a[n] = r; m_b[n] = !r;
        end
        m_rprev[n] = r;
`else
        m_a[n] = r;
        m_b[n] = run && !r;
`endif
      end
      m_period = wrap;
      if (rd_en) m_rd = m_read(addr);
      fl = wr_en && addr == 8'h00 && wdata[1];
      // counter advances with the currently active limits
      if (!run || fl) begin
        m_cnt = 0; m_pc = 0;
      end else if (m_pc == int'(a_psc)) begin
        m_pc  = 0;
        m_cnt = (m_cnt == int'(a_arr)) ? 0 : m_cnt + 1;
      end else begin
        m_pc++;
      end
      // active set copies the shadows as they were before this cycle's write
      if (!m_en || wrap || fl) begin
        a_psc = m_psc; a_arr = m_arr;
        for (int n = 0; n < NCH; n++) a_ccr[n] = m_ccr[n];
      end
      if (wr_en) begin
        if (addr == 8'h00) m_en = wdata[0];
        else if (addr == 8'h01) m_psc = wdata;
        else if (addr == 8'h02) m_arr = wdata;
`ifdef PWM_DEADTIME_EN
        else if (addr == 8'h03) m_dt = wdata;
`endif
        else if (addr >= 8'h10 && int'(addr) < 16 + NCH) m_ccr[int'(addr) - 16] = wdata;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("pwm_a", 32'(pwm_a), 32'(m_a));
      check("pwm_b", 32'(pwm_b), 32'(m_b));
      check("period", 32'(period), 32'(m_period));
      check("rdata", 32'(rdata), 32'(m_rd));
    end
  end

  // ---------------- bus helpers ---------------------------------------------
  task automatic bus_wr(input logic [AW-1:0] a, input logic [W-1:0] d);
    @(posedge clk); #1;
    addr = a; wdata = d; wr_en = 1'b1;
    @(posedge clk); #1;
    wr_en = 1'b0;
  endtask

  task automatic bus_rd(input logic [AW-1:0] a, output logic [W-1:0] d);
    @(posedge clk); #1;
    addr = a; rd_en = 1'b1;
    @(posedge clk); #1;
    rd_en = 1'b0;
    d = rdata;
  endtask

  task automatic wait_period(output int t);
    int k;
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!period && k < 200);
    check("period_seen", 32'(period), 32'd1);
    t = cyc;
  endtask

  task automatic measure(input int ch, input int ncyc,
                         output int ha, output int hb, output int np, output int lo);
    ha = 0; hb = 0; np = 0; lo = 0;
    for (int i = 0; i < ncyc; i++) begin
      @(negedge clk);
      if (pwm_a[ch]) ha++;
      if (pwm_b[ch]) hb++;
      if (period) np++;
      if (!pwm_a[ch] && !pwm_b[ch]) lo++;
    end
  endtask

  task automatic setup(input logic [W-1:0] psc, input logic [W-1:0] arr,
                       input logic [AW-1:0] ccr_a, input logic [W-1:0] ccr_v);
    bus_wr(8'h00, 16'd0);
    bus_wr(8'h01, psc);
    bus_wr(8'h02, arr);
    bus_wr(ccr_a, ccr_v);
  endtask

  // ---------------- stimulus --------------------------------------------------
  initial begin
    logic [W-1:0] d;
    int t0, t1, t2, tf, ha, hb, np, lo, op;

    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    chk_en = 1'b1;

    // reset state
    @(negedge clk);
    check("rst_pwm_a", 32'(pwm_a), 32'd0);
    check("rst_pwm_b", 32'(pwm_b), 32'd0);
    check("rst_period", 32'(period), 32'd0);
    bus_rd(8'h10, d);
    check("rst_ccr0", 32'(d), 32'd0);

    // PSC=0 ARR=9 CCR0=3: 3/10 duty, pulse every 10
    setup(16'd0, 16'd9, 8'h10, 16'd3);
    bus_wr(8'h00, 16'd1);
    wait_period(t0); wait_period(t0);
    measure(0, 20, ha, hb, np, lo);
    check("duty30_a", 32'(ha), 32'd6);
    check("duty30_b", 32'(hb), 32'd14);
    check("duty30_lo", 32'(lo), 32'd0);
    check("duty30_per", 32'(np), 32'd2);
    bus_rd(8'h02, d);
    check("rd_arr", 32'(d), 32'd9);
    bus_rd(8'h00, d);
    check("rd_ctrl", 32'(d), 32'd1);

    // PSC=1 ARR=4 CCR0=2: 10-clk period, A high 4
    setup(16'd1, 16'd4, 8'h10, 16'd2);
    bus_wr(8'h00, 16'd1);
    wait_period(t0); wait_period(t0);
    measure(0, 20, ha, hb, np, lo);
    check("psc1_a", 32'(ha), 32'd8);
    check("psc1_per", 32'(np), 32'd2);

    // CCR1=0 (0%), CCR2=12 > ARR (100%)
    setup(16'd0, 16'd9, 8'h11, 16'd0);
    bus_wr(8'h12, 16'd12);
    bus_wr(8'h00, 16'd1);
    wait_period(t0);
    measure(1, 20, ha, hb, np, lo);
    check("ccr0pct_a", 32'(ha), 32'd0);
    check("ccr0pct_b", 32'(hb), 32'd20);
    measure(2, 20, ha, hb, np, lo);
    check("ccr100pct_a", 32'(ha), 32'd20);

    // mid-period ARR write: current period keeps 10, next is 20
    wait_period(t0);
    repeat (2) @(negedge clk);
    bus_wr(8'h02, 16'd19);
    wait_period(t1);
    wait_period(t2);
    check("shadow_gap_old", 32'(t1 - t0), 32'd10);
    check("shadow_gap_new", 32'(t2 - t1), 32'd20);

    // FORCE_LOAD: new ARR applies at once, counter restarts
    bus_wr(8'h02, 16'd7);
    bus_wr(8'h00, 16'd3);
    tf = cyc;
    wait_period(t1);
    check("force_first", 32'(t1 - tf), 32'd8);
    wait_period(t2);
    check("force_gap", 32'(t2 - t1), 32'd8);
    bus_rd(8'h00, d);
    check("force_selfclr", 32'(d), 32'd1);

    // EN=0 mid-period: outputs low right after the write edge
    repeat (3) @(negedge clk);
    bus_wr(8'h00, 16'd0);
    check("dis_pwm_a", 32'(pwm_a), 32'd0);
    check("dis_pwm_b", 32'(pwm_b), 32'd0);
    check("dis_period", 32'(period), 32'd0);

    // rst mid-period
    bus_wr(8'h00, 16'd1);
    repeat (5) @(negedge clk);
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    check("rstmid_pwm_a", 32'(pwm_a), 32'd0);
    check("rstmid_pwm_b", 32'(pwm_b), 32'd0);
    bus_rd(8'h10, d);
    check("rstmid_ccr0", 32'(d), 32'd0);

    // unmapped and DT register access
    bus_wr(8'h05, 16'hBEEF);
    bus_rd(8'h05, d);
    check("unmapped_05", 32'(d), 32'd0);
    bus_wr(8'h18, 16'h1234);
    bus_rd(8'h18, d);
    check("unmapped_ccr8", 32'(d), 32'd0);
    bus_wr(8'h03, 16'd5);
    bus_rd(8'h03, d);
`ifdef PWM_DEADTIME_EN
    check("dt_read", 32'(d), 32'd5);

    // DT=2 CCR0=5 ARR=9: A 3, B 3, both-low 4 per period
    setup(16'd0, 16'd9, 8'h10, 16'd5);
    bus_wr(8'h03, 16'd2);
    bus_wr(8'h00, 16'd1);
    wait_period(t0); wait_period(t0);
    measure(0, 20, ha, hb, np, lo);
    check("dt2_a", 32'(ha), 32'd6);
    check("dt2_b", 32'(hb), 32'd6);
    check("dt2_lo", 32'(lo), 32'd8);

    // DT=6 CCR0=3: pulse swallowed
    setup(16'd0, 16'd9, 8'h10, 16'd3);
    bus_wr(8'h03, 16'd6);
    bus_wr(8'h00, 16'd1);
    wait_period(t0); wait_period(t0);
    measure(0, 20, ha, hb, np, lo);
    check("dt6_a", 32'(ha), 32'd0);
    bus_wr(8'h03, 16'd0);
`else
    check("dt_read", 32'(d), 32'd0);
`endif

    // randomized traffic, checked every cycle against the model
    bus_wr(8'h00, 16'd1);
    for (int i = 0; i < 3000; i++) begin
      @(posedge clk); #1;
      wr_en = 1'b0; rd_en = 1'b0; rst = 1'b0;
      op = int'($urandom_range(0, 199));
      if (op < 30) begin
        wr_en = 1'b1;
        case ($urandom_range(0, 5))
          0: begin addr = 8'h01; wdata = 16'($urandom_range(0, 3)); end
          1: begin addr = 8'h02; wdata = 16'($urandom_range(0, 15)); end
          2, 3: begin addr = 8'(16 + $urandom_range(0, NCH + 1)); wdata = 16'($urandom_range(0, 18)); end
          4: begin addr = 8'($urandom_range(UNM_LO, 15)); wdata = 16'($urandom); end
          default: begin
            addr  = 8'h00;
            wdata = 16'({($urandom_range(0, 3) == 0), ($urandom_range(0, 9) != 0)});
          end
        endcase
      end else if (op < 70) begin
        rd_en = 1'b1;
        addr  = 8'($urandom_range(0, 31));
      end else if (op == 199) begin
        rst = 1'b1;
      end else if (op == 198) begin
        wr_en = 1'b1; addr = 8'h00; wdata = 16'd1;
      end
    end
    @(posedge clk); #1;
    wr_en = 1'b0; rd_en = 1'b0; rst = 1'b0;
    repeat (3) @(negedge clk);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
